// File: rtl/pipe_rx_pkg.sv
// pipe_rx_pkg: RxStatus encodings and gen-to-width mapping shared by the PIPE RX capture path.
package pipe_rx_pkg;
  typedef enum logic [2:0] {
    STS_OK       = 3'b000,
    STS_SKP_ADD  = 3'b001,
    STS_SKP_REM  = 3'b010,
    STS_DEC_ERR  = 3'b100,
    STS_EB_OVF   = 3'b101,
    STS_EB_UNF   = 3'b110,
    STS_DISP_ERR = 3'b111
  } rx_status_e;

  function automatic logic [5:0] gen_width(input logic [2:0] gen, input int w1, input int w2,
                                           input int w3, input int w4, input int w5);
    return gen == 3'd1 ? 6'(w1) : gen == 3'd2 ? 6'(w2) : gen == 3'd3 ? 6'(w3) :
           gen == 3'd4 ? 6'(w4) : gen == 3'd5 ? 6'(w5) : 6'd0;
  endfunction
endpackage

// File: rtl/pipe_rx_lane_pack.sv
// pipe_rx_lane_pack: one lane's byte accumulator, pointer, block tag and error screening.
module pipe_rx_lane_pack
  import pipe_rx_pkg::*;
#(
  parameter int OUT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             width_i,
  input  logic                   gen3p_i,
  input  logic                   flush_i,
  input  logic                   rx_valid_i,
  input  logic                   rx_start_block_i,
  input  logic [2:0]             rx_status_i,
  input  logic [1:0]             rx_sync_header_i,
  input  logic                   rx_elec_idle_i,
  input  logic [31:0]            rx_data_i,
  input  logic [3:0]             rx_datak_i,
  output logic                   out_valid_o,
  output logic [OUT_WIDTH-1:0]   out_data_o,
  output logic [OUT_WIDTH/8-1:0] out_datak_o,
  output logic                   out_block_start_o,
  output logic [1:0]             out_sync_header_o,
  output logic                   out_elec_idle_o,
  output logic                   err_pulse_o
);
  localparam int NB = OUT_WIDTH / 8;
  localparam int PW = $clog2(NB) + 1;
  logic [OUT_WIDTH-1:0] acc_q, acc_d, dat_q, dat_d;
  logic [NB-1:0] acck_q, acck_d, datk_q, datk_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [1:0] hdr_q, hdr_d, ohdr_q, ohdr_d;
  logic tag_q, tag_d, vld_q, vld_d, bs_q, bs_d, err_q, err_d, ei_q;
  logic sts_err, accept, blk;
  int nb, base;
  assign nb      = int'(width_i) / 8;
  assign sts_err = rx_valid_i && (rx_status_i inside {STS_DEC_ERR, STS_EB_OVF, STS_EB_UNF, STS_DISP_ERR});
  assign accept  = rx_valid_i && !sts_err && nb != 0;
  assign blk     = accept && gen3p_i && rx_start_block_i;
  // Priority: GEN flush > electrical idle > status error > block start > append
  always_comb begin
    acc_d  = acc_q;
    acck_d = acck_q;
    ptr_d  = ptr_q;
    tag_d  = tag_q;
    hdr_d  = hdr_q;
    dat_d  = dat_q;
    datk_d = datk_q;
    vld_d  = 1'b0;
    bs_d   = 1'b0;
    ohdr_d = 2'b00;
    err_d  = 1'b0;
    base   = blk ? 0 : int'(ptr_q);
    if (flush_i || rx_elec_idle_i || sts_err) begin
      ptr_d = '0;
      tag_d = 1'b0;
      hdr_d = 2'b00;
      err_d = flush_i ? ptr_q != '0 : !rx_elec_idle_i;
    end else if (accept) begin
      for (int b = 0; b < 4; b++)
        if (b < nb && base + b < NB) begin
          acc_d[8*(base+b) +: 8] = rx_data_i[8*b +: 8];
          acck_d[base+b]         = !gen3p_i && rx_datak_i[b];
        end
      err_d = blk && ptr_q != '0;
      if (base + nb == NB) begin
        vld_d  = 1'b1;
        dat_d  = acc_d;
        datk_d = acck_d;
        bs_d   = blk || tag_q;
        ohdr_d = blk ? rx_sync_header_i : hdr_q;
        ptr_d  = '0;
        tag_d  = 1'b0;
        hdr_d  = 2'b00;
      end else begin
        ptr_d = PW'(base + nb);
        tag_d = blk || tag_q;
        hdr_d = blk ? rx_sync_header_i : hdr_q;
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc_q  <= '0;
      acck_q <= '0;
      ptr_q  <= '0;
      tag_q  <= 1'b0;
      hdr_q  <= 2'b00;
      dat_q  <= '0;
      datk_q <= '0;
      vld_q  <= 1'b0;
      bs_q   <= 1'b0;
      ohdr_q <= 2'b00;
      err_q  <= 1'b0;
      ei_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      acck_q <= acck_d;
      ptr_q  <= ptr_d;
      tag_q  <= tag_d;
      hdr_q  <= hdr_d;
      dat_q  <= dat_d;
      datk_q <= datk_d;
      vld_q  <= vld_d;
      bs_q   <= bs_d;
      ohdr_q <= ohdr_d;
      err_q  <= err_d;
      ei_q   <= rx_elec_idle_i;
    end
  assign out_valid_o       = vld_q;
  assign out_data_o        = dat_q;
  assign out_datak_o       = datk_q;
  assign out_block_start_o = bs_q;
  assign out_sync_header_o = ohdr_q;
  assign out_elec_idle_o   = ei_q;
  assign err_pulse_o       = err_q;
endmodule

// File: rtl/pipe_rx_lane_packer.sv
// pipe_rx_lane_packer: multi-lane PIPE RX capture; packs per-GEN-width beats into fixed words.
// Holds the shared GEN register whose change flushes every lane.
module pipe_rx_lane_packer
  import pipe_rx_pkg::*;
#(
  parameter int LANES          = 4,
  parameter int OUT_WIDTH      = 32,
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 16,
  parameter int GEN3_PIPEWIDTH = 32,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [2:0]                     gen_i,
  input  logic [LANES-1:0]               rx_valid_i,
  input  logic [LANES-1:0]               rx_start_block_i,
  input  logic [3*LANES-1:0]             rx_status_i,
  input  logic [2*LANES-1:0]             rx_sync_header_i,
  input  logic [LANES-1:0]               rx_elec_idle_i,
  input  logic [32*LANES-1:0]            rx_data_i,
  input  logic [4*LANES-1:0]             rx_datak_i,
  output logic [LANES-1:0]               out_valid_o,
  output logic [OUT_WIDTH*LANES-1:0]     out_data_o,
  output logic [(OUT_WIDTH/8)*LANES-1:0] out_datak_o,
  output logic [LANES-1:0]               out_block_start_o,
  output logic [2*LANES-1:0]             out_sync_header_o,
  output logic [LANES-1:0]               out_elec_idle_o,
  output logic [LANES-1:0]               err_pulse_o,
  output logic [5:0]                     pipe_width_o
);
  localparam int NB = OUT_WIDTH / 8;
  logic [2:0] gen_q;
  logic [5:0] pw_q;
  logic gen_chg, gen3p;
  assign gen_chg = gen_i != gen_q;
  assign gen3p   = gen_q >= 3'd3 && pw_q != 6'd0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      gen_q <= 3'd0;
      pw_q  <= 6'd0;
    end else begin
      gen_q <= gen_i;
      pw_q  <= gen_width(gen_i, GEN1_PIPEWIDTH, GEN2_PIPEWIDTH, GEN3_PIPEWIDTH, GEN4_PIPEWIDTH, GEN5_PIPEWIDTH);
    end
  assign pipe_width_o = pw_q;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pipe_rx_lane_pack #(.OUT_WIDTH(OUT_WIDTH)) u_lane (
      .clk               (clk),
      .reset             (reset),
      .width_i           (pw_q),
      .gen3p_i           (gen3p),
      .flush_i           (gen_chg),
      .rx_valid_i        (rx_valid_i[g]),
      .rx_start_block_i  (rx_start_block_i[g]),
      .rx_status_i       (rx_status_i[3*g +: 3]),
      .rx_sync_header_i  (rx_sync_header_i[2*g +: 2]),
      .rx_elec_idle_i    (rx_elec_idle_i[g]),
      .rx_data_i         (rx_data_i[32*g +: 32]),
      .rx_datak_i        (rx_datak_i[4*g +: 4]),
      .out_valid_o       (out_valid_o[g]),
      .out_data_o        (out_data_o[OUT_WIDTH*g +: OUT_WIDTH]),
      .out_datak_o       (out_datak_o[NB*g +: NB]),
      .out_block_start_o (out_block_start_o[g]),
      .out_sync_header_o (out_sync_header_o[2*g +: 2]),
      .out_elec_idle_o   (out_elec_idle_o[g]),
      .err_pulse_o       (err_pulse_o[g])
    );
  end
endmodule
